// File: rtl/dsa_run_ctrl.sv
// Run sequencer for the bilinear DSA: clears out-BRAM, launches one core with a latched mode,
// then waits for done with watchdog and abort, and reports sticky status plus a saturating cycle count.
module dsa_run_ctrl #(
  parameter int AW             = 12,
  parameter int TIMEOUT_W      = 24,
  parameter bit CLR_BEFORE_RUN = 1'b1
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          start_req,
  input  logic          abort_req,
  input  logic          mode_simd_req,
  input  logic          busy_seq,
  input  logic          busy_simd,
  input  logic          done_seq,
  input  logic          done_simd,
  output logic          start_seq,
  output logic          start_simd,
  output logic          mode_simd_lat,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          in_we_allow,
  output logic          busy,
  output logic          done,
  output logic          err_timeout,
  output logic [31:0]   run_cycles
);

  // state   | meaning
  // RST_CLR | post-reset out-BRAM clear sweep
  // IDLE    | waiting for start, no result yet
  // PRE_CLR | per-run out-BRAM clear sweep
  // LAUNCH  | one-cycle start pulse to the selected core
  // WAIT    | waiting for selected core done, watchdog running
  // DRAIN   | aborted, waiting for selected core to go idle
  // DONE    | run completed
  // ERR     | watchdog expired
  typedef enum logic [2:0] {
    RST_CLR = 3'd0,
    IDLE    = 3'd1,
    PRE_CLR = 3'd2,
    LAUNCH  = 3'd3,
    WAIT    = 3'd4,
    DRAIN   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        clr_addr_q, clr_addr_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic                 sel_done, sel_busy;
  logic                 clr_last;
  logic [TIMEOUT_W-1:0] wdog_inc;
  logic                 wdog_term;
  logic [31:0]          cyc_inc;

  assign sel_done  = mode_q ? done_simd : done_seq;
  assign sel_busy  = mode_q ? busy_simd : busy_seq;
  assign clr_last  = &clr_addr_q;
  assign wdog_inc  = wdog_q + TIMEOUT_W'(1);
  assign wdog_term = &wdog_inc;
  assign cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + 32'd1;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_CLR;
      clr_addr_q <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cyc_q      <= '0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      wdog_q     <= wdog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mode_d     = mode_q;
    done_d     = done_q;
    err_d      = err_q;
    cyc_d      = cyc_q;
    wdog_d     = wdog_q;
    case (state_q)
      RST_CLR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_last) state_d = IDLE;
      end
      IDLE, DONE, ERR: begin
        // abort has priority over a coincident start
        if (abort_req) begin
          state_d = IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (start_req) begin
          mode_d     = mode_simd_req;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cyc_d      = '0;
          wdog_d     = '0;
          clr_addr_d = '0;
          state_d    = CLR_BEFORE_RUN ? PRE_CLR : LAUNCH;
        end
      end
      PRE_CLR: begin
        if (abort_req) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
          if (clr_last) state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cyc_d   = cyc_inc;
        state_d = abort_req ? DRAIN : WAIT;
      end
      WAIT: begin
        cyc_d  = cyc_inc;
        wdog_d = wdog_inc;
        // done beats a coincident watchdog expiry; abort beats both
        if (abort_req) begin
          state_d = DRAIN;
        end else if (sel_done) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (wdog_term) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (!sel_busy) state_d = IDLE;
      end
      default: state_d = RST_CLR;
    endcase
  end

  assign start_seq     = (state_q == LAUNCH) && !mode_q;
  assign start_simd    = (state_q == LAUNCH) && mode_q;
  assign mode_simd_lat = mode_q;
  assign clr_we        = (state_q == RST_CLR) || (state_q == PRE_CLR);
  assign clr_addr      = clr_addr_q;
  assign in_we_allow   = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign busy          = !in_we_allow;
  assign done          = done_q;
  assign err_timeout   = err_q;
  assign run_cycles    = cyc_q;

endmodule

// File: tb/tb_dsa_run_ctrl.sv
// Directed bench for dsa_run_ctrl with AW=4, TIMEOUT_W=6, clear before every run.
module tb_dsa_run_ctrl;

  localparam int AW = 4;

  logic          clk_50 = 1'b0;
  logic          rst_n;
  logic          start_req, abort_req, mode_simd_req;
  logic          busy_seq, busy_simd, done_seq, done_simd;
  logic          start_seq, start_simd, mode_simd_lat, clr_we;
  logic [AW-1:0] clr_addr;
  logic          in_we_allow, busy, done, err_timeout;
  logic [31:0]   run_cycles;

  int n_chk  = 0;
  int n_fail = 0;
  int n_seq  = 0;
  int n_simd = 0;
  int n_both = 0;

  dsa_run_ctrl #(.AW(AW), .TIMEOUT_W(6), .CLR_BEFORE_RUN(1'b1)) dut (
    .clk_50        (clk_50),
    .rst_n         (rst_n),
    .start_req     (start_req),
    .abort_req     (abort_req),
    .mode_simd_req (mode_simd_req),
    .busy_seq      (busy_seq),
    .busy_simd     (busy_simd),
    .done_seq      (done_seq),
    .done_simd     (done_simd),
    .start_seq     (start_seq),
    .start_simd    (start_simd),
    .mode_simd_lat (mode_simd_lat),
    .clr_we        (clr_we),
    .clr_addr      (clr_addr),
    .in_we_allow   (in_we_allow),
    .busy          (busy),
    .done          (done),
    .err_timeout   (err_timeout),
    .run_cycles    (run_cycles)
  );

  always #5 clk_50 = ~clk_50;

  // launch pulses tallied at the edge that consumes them
  always @(posedge clk_50) begin
    if (start_seq)  n_seq++;
    if (start_simd) n_simd++;
    if (start_seq && start_simd) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk_50);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0;
    start_req = 1'b0; abort_req = 1'b0; mode_simd_req = 1'b0;
    busy_seq = 1'b0; busy_simd = 1'b0; done_seq = 1'b0; done_simd = 1'b0;
    tick();
    check("rst_clr_we",   32'(clr_we), 32'd1);
    check("rst_busy",     32'(busy), 32'd1);
    check("rst_in_we",    32'(in_we_allow), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_err",      32'(err_timeout), 32'd0);
    check("rst_cycles",   run_cycles, 32'd0);
    check("rst_addr",     32'(clr_addr), 32'd0);
    check("rst_mode",     32'(mode_simd_lat), 32'd0);
    check("rst_start",    32'({start_seq, start_simd}), 32'd0);
    rst_n = 1'b1;

    // post-reset sweep; start and abort inside it must be ignored
    for (int i = 0; i < 16; i++) begin
      check("rstclr_we", 32'(clr_we), 32'd1);
      check("rstclr_addr", 32'(clr_addr), 32'(i));
      start_req = (i == 5);
      abort_req = (i == 7);
      tick();
    end
    start_req = 1'b0; abort_req = 1'b0;
    check("idle_clr_we", 32'(clr_we), 32'd0);
    check("idle_busy",   32'(busy), 32'd0);
    check("idle_in_we",  32'(in_we_allow), 32'd1);
    check("idle_addr",   32'(clr_addr), 32'd0);
    tick(2);
    check("rstclr_no_launch", 32'(n_seq + n_simd), 32'd0);

    // SIMD run: pre-clear, launch, done 10 cycles after LAUNCH
    start_req = 1'b1; mode_simd_req = 1'b1;
    tick();
    start_req = 1'b0; mode_simd_req = 1'b0;
    check("run1_mode", 32'(mode_simd_lat), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("preclr_we", 32'(clr_we), 32'd1);
      check("preclr_addr", 32'(clr_addr), 32'(i));
      tick();
    end
    check("run1_clr_we_off", 32'(clr_we), 32'd0);
    check("run1_start_simd", 32'(start_simd), 32'd1);
    check("run1_start_seq",  32'(start_seq), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      start_req = (i == 3);
      mode_simd_req = (i == 4);
      done_simd = (i == 10);
    end
    tick();
    start_req = 1'b0; done_simd = 1'b0; mode_simd_req = 1'b0;
    check("run1_done",   32'(done), 32'd1);
    check("run1_cycles", run_cycles, 32'd11);
    check("run1_busy",   32'(busy), 32'd0);
    check("run1_mode_kept", 32'(mode_simd_lat), 32'd1);
    tick(3);
    check("run1_cycles_held", run_cycles, 32'd11);
    check("run1_simd_pulses", 32'(n_simd), 32'd1);
    check("run1_seq_pulses",  32'(n_seq), 32'd0);

    // seq run that times out; a done_simd pulse must be ignored
    start_req = 1'b1; mode_simd_req = 1'b0;
    tick();
    start_req = 1'b0;
    check("run2_done_clr",   32'(done), 32'd0);
    check("run2_cycles_clr", run_cycles, 32'd0);
    tick(16);
    check("run2_start_seq", 32'(start_seq), 32'd1);
    tick();
    for (int i = 1; i < 63; i++) begin
      done_simd = (i == 20);
      tick();
    end
    done_simd = 1'b0;
    check("run2_wait63_busy", 32'(busy), 32'd1);
    check("run2_wait63_err",  32'(err_timeout), 32'd0);
    tick();
    check("run2_err",    32'(err_timeout), 32'd1);
    check("run2_busy",   32'(busy), 32'd0);
    check("run2_done",   32'(done), 32'd0);
    check("run2_cycles", run_cycles, 32'd64);

    // restart from ERR clears the flag; done on the first WAIT cycle
    start_req = 1'b1; mode_simd_req = 1'b1;
    tick();
    start_req = 1'b0;
    check("run3_err_clr",    32'(err_timeout), 32'd0);
    check("run3_cycles_clr", run_cycles, 32'd0);
    tick(17);
    done_simd = 1'b1;
    tick();
    done_simd = 1'b0;
    check("run3_done",   32'(done), 32'd1);
    check("run3_cycles", run_cycles, 32'd2);
    check("run3_pulses", 32'(n_simd * 16 + n_seq), 32'd33);

    // abort in DONE clears done
    abort_req = 1'b1;
    tick();
    abort_req = 1'b0;
    check("abort_done_clr", 32'(done), 32'd0);
    check("abort_done_idle", 32'(in_we_allow), 32'd1);

    // abort in WAIT with seq core busy: drain until busy drops
    start_req = 1'b1; mode_simd_req = 1'b0;
    tick();
    start_req = 1'b0;
    tick(17);
    tick(2);
    abort_req = 1'b1; busy_seq = 1'b1;
    tick();
    abort_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      done_simd = (i == 1);
      check("drain_busy", 32'(busy), 32'd1);
      tick();
    end
    done_simd = 1'b0;
    busy_seq = 1'b0;
    check("drain_last_busy", 32'(busy), 32'd1);
    tick();
    check("drain_idle",  32'(in_we_allow), 32'd1);
    check("drain_done",  32'(done), 32'd0);
    check("drain_pulses", 32'(n_simd * 16 + n_seq), 32'd34);

    // start and abort in the same IDLE cycle
    start_req = 1'b1; abort_req = 1'b1;
    tick();
    start_req = 1'b0; abort_req = 1'b0;
    check("both_idle",  32'(busy), 32'd0);
    check("both_no_clr", 32'(clr_we), 32'd0);
    tick(3);
    check("both_no_launch", 32'(n_simd * 16 + n_seq), 32'd34);

    // async reset mid-sweep restarts the post-reset clear
    start_req = 1'b1; mode_simd_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midrst_addr", 32'(clr_addr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_mode", 32'(mode_simd_lat), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(15);
    check("midrst_last_addr", 32'(clr_addr), 32'd15);
    tick();
    check("midrst_idle", 32'(in_we_allow), 32'd1);
    check("never_both", 32'(n_both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
